// File: rtl/dmem_io_pkg.sv
// rtl/dmem_io_pkg.sv - shared address map for the data-memory responder
// Purpose: I/O page base, register offsets within the page, TCTRL bit
//          positions and small address-decode helpers.
// Ports:   none (package).
package dmem_io_pkg;

  // Any address with this bit set falls in the I/O page.
  localparam logic [15:0] IO_BASE = 16'h8000;

  // Register offsets, selected by addr[3:1].
  localparam logic [2:0] REG_LED    = 3'd0;
  localparam logic [2:0] REG_SW     = 3'd1;
  localparam logic [2:0] REG_TCOUNT = 3'd2;
  localparam logic [2:0] REG_TCTRL  = 3'd3;

  // TCTRL bit positions.
  localparam int TCTRL_EN_BIT   = 0;
  localparam int TCTRL_FLAG_BIT = 1;

  function automatic logic is_io(input logic [15:0] a);
    return (a & IO_BASE) != 16'h0000;
  endfunction

  // addr[14:4] is ignored, so the I/O page aliases across that range.
  function automatic logic [2:0] io_reg(input logic [15:0] a);
    return a[3:1];
  endfunction

endpackage

// File: rtl/dmem_io_responder_if.sv
// rtl/dmem_io_responder_if.sv - datapath data-port bus
// Purpose: groups the single-cycle data-port signals between datapath and
//          memory responder.
// Signals: memwrite  - write strobe
//          addr      - byte address (ALU result)
//          writedata - store data
//          readdata  - load data, combinational from addr
interface dmem_io_responder_if;

  logic        memwrite;
  logic [15:0] addr;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output memwrite,
    output addr,
    output writedata,
    input  readdata
  );

  modport slave (
    input  memwrite,
    input  addr,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - switch synchronizer and debouncer
// Purpose: two-flop synchronizer followed by a stability counter; the
//          output only follows the input after DEB_CYCLES consecutive
//          samples that disagree with the currently accepted value.
// Ports:   clk   - system clock
//          reset - asynchronous active-low reset
//          din   - raw switch inputs, asynchronous to clk
//          dout  - debounced value
module sw_debounce #(
  parameter int          WIDTH      = 3,
  parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sw_s;
  logic [15:0]      count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sw_s  <= '0;
      count <= 16'd0;
      dout  <= '0;
    end else begin
      sync1 <= din;
      sw_s  <= sync1;
      if (sw_s != dout) begin
        // Terminal count: this is the DEB_CYCLES-th consecutive disagreeing sample.
        if (count == DEB_CYCLES - 16'd1) begin
          dout  <= sw_s;
          count <= 16'd0;
        end else begin
          count <= count + 16'd1;
        end
      end else begin
        // Any agreeing sample restarts the stability window.
        count <= 16'd0;
      end
    end
  end

endmodule

// File: rtl/dmem_io_responder.sv
// rtl/dmem_io_responder.sv - data-memory responder with RAM and I/O page
// Purpose: decodes the datapath data port into a word RAM (addr[15]=0) and
//          an I/O page (addr[15]=1) holding LED, debounced switches, a
//          prescaled timer count and timer control. Reads are combinational.
// Ports:   clk      - system clock, rising edge
//          reset    - asynchronous active-low reset
//          bus      - data-port bus (slave side)
//          sw_raw   - raw board switches
//          led      - LED register
//          tmr_flag - sticky timer-wrap flag
module dmem_io_responder
  import dmem_io_pkg::*;
#(
  parameter int          RAM_AW     = 7,
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter logic [15:0] PRESCALE   = 16'd1000
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_io_responder_if.slave   bus,
  input  logic [2:0]           sw_raw,
  output logic [15:0]          led,
  output logic                 tmr_flag
);

  localparam int DEPTH = 2 ** RAM_AW;

  logic [15:0]       mem [DEPTH];
  logic [RAM_AW-1:0] widx;
  logic              io_sel;
  logic [2:0]        rsel;
  logic              wr_ram;
  logic              wr_led;
  logic              wr_tcount;
  logic              wr_tctrl;

  logic [2:0]        sw_db;
  logic [15:0]       prescaler;
  logic [15:0]       tcount;
  logic              tmr_en;
  logic              tick;
  logic              wrap;
  logic [15:0]       tctrl_rd;

  // Byte address -> word index; upper RAM-side bits alias.
  assign widx   = bus.addr[RAM_AW:1];
  assign io_sel = is_io(bus.addr);
  assign rsel   = io_reg(bus.addr);

  assign wr_ram    = bus.memwrite && !io_sel;
  assign wr_led    = bus.memwrite && io_sel && (rsel == REG_LED);
  assign wr_tcount = bus.memwrite && io_sel && (rsel == REG_TCOUNT);
  assign wr_tctrl  = bus.memwrite && io_sel && (rsel == REG_TCTRL);

  sw_debounce #(
    .WIDTH      (3),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sw_debounce (
    .clk   (clk),
    .reset (reset),
    .din   (sw_raw),
    .dout  (sw_db)
  );

  // RAM contents are never cleared; the reset branch only blocks writes
  // on edges where reset is held low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
    end else if (wr_ram) begin
      mem[widx] <= bus.writedata;
    end
  end

  assign tick = tmr_en && (prescaler == PRESCALE - 16'd1);
  assign wrap = tick && (tcount == 16'hFFFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led       <= 16'h0000;
      prescaler <= 16'd0;
      tcount    <= 16'd0;
      tmr_en    <= 1'b0;
      tmr_flag  <= 1'b0;
    end else begin
      if (wr_led) begin
        led <= bus.writedata;
      end

      // A CPU write to TCOUNT beats a same-edge tick and also restarts the prescaler.
      if (wr_tcount) begin
        prescaler <= 16'd0;
        tcount    <= 16'd0;
      end else if (tmr_en) begin
        prescaler <= tick ? 16'd0 : prescaler + 16'd1;
        if (tick) begin
          tcount <= tcount + 16'd1;
        end
      end

      // Setting on a wrap beats a same-edge software clear.
      if (wrap && !wr_tcount) begin
        tmr_flag <= 1'b1;
      end else if (wr_tctrl && bus.writedata[TCTRL_FLAG_BIT]) begin
        tmr_flag <= 1'b0;
      end

      if (wr_tctrl) begin
        tmr_en <= bus.writedata[TCTRL_EN_BIT];
      end
    end
  end

  always_comb begin
    tctrl_rd                 = 16'h0000;
    tctrl_rd[TCTRL_EN_BIT]   = tmr_en;
    tctrl_rd[TCTRL_FLAG_BIT] = tmr_flag;
  end

  always_comb begin
    bus.readdata = 16'h0000;
    if (!io_sel) begin
      bus.readdata = mem[widx];
    end else begin
      case (rsel)
        REG_LED:    bus.readdata = led;
        REG_SW:     bus.readdata = {13'b0, sw_db};
        REG_TCOUNT: bus.readdata = tcount;
        REG_TCTRL:  bus.readdata = tctrl_rd;
        default:    bus.readdata = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_io_responder.sv
// tb/tb_dmem_io_responder.sv - scoreboard bench for dmem_io_responder
module tb_dmem_io_responder;

  localparam int RAM_AW = 7;
  localparam int DEPTH  = 2 ** RAM_AW;
  localparam int DEB    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  sw_raw;
  logic [15:0] led0, led1;
  logic        flag0, flag1;

  dmem_io_responder_if bus0 ();
  dmem_io_responder_if bus1 ();

  dmem_io_responder #(
    .RAM_AW(RAM_AW), .DEB_CYCLES(16'd4), .PRESCALE(16'd2)
  ) dut0 (
    .clk(clk), .reset(rst_n), .bus(bus0), .sw_raw(sw_raw), .led(led0), .tmr_flag(flag0)
  );

  dmem_io_responder #(
    .RAM_AW(RAM_AW), .DEB_CYCLES(16'd4), .PRESCALE(16'd1)
  ) dut1 (
    .clk(clk), .reset(rst_n), .bus(bus1), .sw_raw(sw_raw), .led(led1), .tmr_flag(flag1)
  );

  // Reference model state
  logic [15:0] m_ram [int];
  logic [15:0] m_led;
  logic [2:0]  m_db, m_s1, m_s2;
  int          m_run;
  logic [15:0] m_tc [2];
  int          m_phase [2];
  bit          m_en [2];
  bit          m_flag [2];
  int          ps [2] = '{2, 1};

  typedef struct {
    logic [15:0] rd0;
    logic [15:0] rd1;
    logic [15:0] led;
    logic        flag0;
    logic        flag1;
    string       name;
  } exp_t;

  exp_t exp_q [$];
  exp_t e;
  bit   rd_req = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   widx_q [$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  function automatic void model_reset();
    m_led = 16'h0000;
    m_db  = 3'b000;
    m_s1  = 3'b000;
    m_s2  = 3'b000;
    m_run = 0;
    for (int k = 0; k < 2; k++) begin
      m_tc[k]    = 16'h0000;
      m_phase[k] = 0;
      m_en[k]    = 1'b0;
      m_flag[k]  = 1'b0;
    end
  endfunction

  function automatic logic [15:0] model_read(input int k, input logic [15:0] a);
    logic [2:0] r;
    int idx;
    r   = a[3:1];
    idx = int'(a >> 1) % DEPTH;
    if (!a[15]) return m_ram.exists(idx) ? m_ram[idx] : 16'hxxxx;
    case (r)
      3'd0:    return m_led;
      3'd1:    return {13'b0, m_db};
      3'd2:    return m_tc[k];
      3'd3:    return {14'b0, m_flag[k], m_en[k]};
      default: return 16'h0000;
    endcase
  endfunction

  // One rising clock edge of the specified behaviour.
  function automatic void model_step(input bit we, input logic [15:0] a,
                                     input logic [15:0] wd, input logic [2:0] raw);
    bit io, wr_tc, wr_ctl, wrapped;
    logic [2:0] r;
    if (!rst_n) begin
      model_reset();
      return;
    end
    io = a[15];
    r  = a[3:1];
    // Accept the synchronised value once it has disagreed for DEB samples in a row.
    if (m_s2 != m_db) begin
      m_run++;
      if (m_run == DEB) begin
        m_db  = m_s2;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = raw;
    wr_tc  = we && io && (r == 3'd2);
    wr_ctl = we && io && (r == 3'd3);
    for (int k = 0; k < 2; k++) begin
      wrapped = 1'b0;
      if (wr_tc) begin
        m_tc[k]    = 16'h0000;
        m_phase[k] = 0;
      end else if (m_en[k]) begin
        m_phase[k]++;
        if (m_phase[k] == ps[k]) begin
          m_phase[k] = 0;
          wrapped    = (m_tc[k] == 16'hFFFF);
          m_tc[k]    = m_tc[k] + 16'd1;
        end
      end
      if (wrapped) m_flag[k] = 1'b1;
      else if (wr_ctl && wd[1]) m_flag[k] = 1'b0;
      if (wr_ctl) m_en[k] = wd[0];
    end
    if (we && !io) m_ram[int'(a >> 1) % DEPTH] = wd;
    if (we && io && (r == 3'd0)) m_led = wd;
  endfunction

  // Drive one bus cycle just after a rising edge; optionally queue the
  // expected response, which the monitor checks on the falling edge.
  task automatic bus_op(input bit we, input logic [15:0] a, input logic [15:0] wd,
                        input bit chk_en, input string nm);
    exp_t x;
    bus0.memwrite = we; bus0.addr = a; bus0.writedata = wd;
    bus1.memwrite = we; bus1.addr = a; bus1.writedata = wd;
    if (!rst_n) model_reset();
    if (chk_en) begin
      x.rd0   = model_read(0, a);
      x.rd1   = model_read(1, a);
      x.led   = m_led;
      x.flag0 = m_flag[0];
      x.flag1 = m_flag[1];
      x.name  = nm;
      exp_q.push_back(x);
      rd_req = 1'b1;
    end
    @(posedge clk);
    model_step(we, a, wd, sw_raw);
    #1;
    rd_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rd_req) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "/rd0"}, bus0.readdata, e.rd0);
        chk({e.name, "/rd1"}, bus1.readdata, e.rd1);
        chk({e.name, "/led0"}, led0, e.led);
        chk({e.name, "/led1"}, led1, e.led);
        chk({e.name, "/flag0"}, {15'b0, flag0}, {15'b0, e.flag0});
        chk({e.name, "/flag1"}, {15'b0, flag1}, {15'b0, e.flag1});
      end
    end
  end

  initial begin
    logic [15:0] a, d;
    int idx, guard;
    rst_n = 1'b0;
    sw_raw = 3'b000;
    bus0.memwrite = 1'b0; bus0.addr = 16'h0; bus0.writedata = 16'h0;
    bus1.memwrite = 1'b0; bus1.addr = 16'h0; bus1.writedata = 16'h0;
    model_reset();
    @(posedge clk);
    #1;
    bus_op(1'b0, 16'h0000, 16'h0000, 1'b0, "idle");
    bus_op(1'b0, 16'h0000, 16'h0000, 1'b0, "idle");
    rst_n = 1'b1;

    // Reset state of the I/O page
    for (int i = 0; i < 4; i++) bus_op(1'b0, 16'h8000 + 16'(2 * i), 16'h0, 1'b1, "reset_io");

    // RAM: odd byte ignored, index wraps modulo depth
    bus_op(1'b1, 16'h0010, 16'hBEEF, 1'b0, "wr");
    bus_op(1'b0, 16'h0010, 16'h0, 1'b1, "ram_beef");
    bus_op(1'b1, 16'h0011, 16'h1234, 1'b0, "wr");
    bus_op(1'b0, 16'h0010, 16'h0, 1'b1, "ram_odd_byte");
    bus_op(1'b1, 16'h0010 + 16'(2 * DEPTH), 16'h5A5A, 1'b0, "wr");
    bus_op(1'b0, 16'h0010, 16'h0, 1'b1, "ram_wrap");
    widx_q.push_back(8);

    // LED, aliases and unmapped registers
    bus_op(1'b1, 16'h8000, 16'hA5A5, 1'b0, "wr");
    bus_op(1'b0, 16'h8000, 16'h0, 1'b1, "led_a5a5");
    bus_op(1'b1, 16'h800A, 16'hFFFF, 1'b0, "wr");
    bus_op(1'b0, 16'h800A, 16'h0, 1'b1, "unmapped_a");
    bus_op(1'b1, 16'h800E, 16'h1357, 1'b0, "wr");
    bus_op(1'b0, 16'h800E, 16'h0, 1'b1, "unmapped_e");
    bus_op(1'b0, 16'h8FF0, 16'h0, 1'b1, "io_alias_led");

    // Random RAM and LED traffic
    for (int i = 0; i < 60; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        a = 16'h8000 | (16'($urandom) & 16'h7FF0);
        bus_op(1'b1, a, d, 1'b0, "wr");
        bus_op(1'b0, 16'h8000, 16'h0, 1'b1, "rand_led");
      end else if ($urandom_range(0, 1) == 0 || widx_q.size() == 0) begin
        idx = $urandom_range(0, DEPTH - 1);
        a = 16'(idx * 2) | (16'($urandom) & 16'h7F01);
        bus_op(1'b1, a, d, 1'b0, "wr");
        widx_q.push_back(idx);
      end else begin
        idx = widx_q[$urandom_range(0, widx_q.size() - 1)];
        a = 16'(idx * 2) | (16'($urandom) & 16'h7F01);
        bus_op(1'b0, a, 16'h0, 1'b1, "rand_ram");
      end
    end

    // Switch latency: clean change, then read every cycle
    sw_raw = 3'b101;
    for (int i = 0; i < 8; i++) bus_op(1'b0, 16'h8002, 16'h0, 1'b1, "sw_latency");
    // Three-cycle glitch must be filtered
    sw_raw = 3'b010;
    for (int i = 0; i < 3; i++) bus_op(1'b0, 16'h8002, 16'h0, 1'b1, "sw_glitch");
    sw_raw = 3'b101;
    for (int i = 0; i < 8; i++) bus_op(1'b0, 16'h8002, 16'h0, 1'b1, "sw_glitch_after");
    // Random switch segments
    for (int s = 0; s < 12; s++) begin
      sw_raw = 3'($urandom_range(0, 7));
      for (int i = 0; i < $urandom_range(1, 8); i++) bus_op(1'b0, 16'h8002, 16'h0, 1'b1, "sw_rand");
    end

    // Timer basic counting
    bus_op(1'b1, 16'h8006, 16'h0001, 1'b0, "wr");
    for (int i = 0; i < 12; i++) bus_op(1'b0, 16'h8004, 16'h0, 1'b1, "tcount_run");
    bus_op(1'b0, 16'h8006, 16'h0, 1'b1, "tctrl_run");
    // TCOUNT write on a tick edge of the prescaled instance
    guard = 0;
    while (m_phase[0] != ps[0] - 1 && guard < 10) begin
      bus_op(1'b0, 16'h0000, 16'h0, 1'b0, "adv");
      guard++;
    end
    bus_op(1'b1, 16'h8004, 16'h7777, 1'b1, "tcount_wr_race_pre");
    bus_op(1'b0, 16'h8004, 16'h0, 1'b1, "tcount_wr_race");
    for (int i = 0; i < 3; i++) bus_op(1'b0, 16'h8004, 16'h0, 1'b1, "tcount_after_clr");
    // Freeze
    bus_op(1'b1, 16'h8006, 16'h0000, 1'b0, "wr");
    for (int i = 0; i < 4; i++) bus_op(1'b0, 16'h8004, 16'h0, 1'b1, "tcount_frozen");
    bus_op(1'b1, 16'h8006, 16'h0001, 1'b0, "wr");
    bus_op(1'b1, 16'h8004, 16'h0000, 1'b0, "wr");

    // Run the unprescaled instance up to 16'hFFFF
    guard = 0;
    while (m_tc[1] != 16'hFFFF && guard < 70000) begin
      bus_op(1'b0, 16'h0000, 16'h0, 1'b0, "run");
      guard++;
    end
    bus_op(1'b0, 16'h8004, 16'h0, 1'b1, "tcount_ffff");
    // tcount_ffff consumed one tick; restart the approach for the race edge
    guard = 0;
    while (m_tc[1] != 16'hFFFF && guard < 70000) begin
      bus_op(1'b0, 16'h0000, 16'h0, 1'b0, "run");
      guard++;
    end
    // Flag-clear on the wrap edge: set wins
    bus_op(1'b1, 16'h8006, 16'h0003, 1'b1, "wrap_race_pre");
    bus_op(1'b0, 16'h8006, 16'h0, 1'b1, "wrap_race_flag");
    bus_op(1'b0, 16'h8004, 16'h0, 1'b1, "tcount_after_wrap");
    bus_op(1'b1, 16'h8006, 16'h0003, 1'b0, "wr");
    bus_op(1'b0, 16'h8006, 16'h0, 1'b1, "flag_cleared_en_kept");

    // Asynchronous reset mid-operation
    bus_op(1'b1, 16'h8000, 16'hFFFF, 1'b0, "wr");
    sw_raw = 3'b111;
    for (int i = 0; i < 10; i++) bus_op(1'b0, 16'h8002, 16'h0, 1'b1, "sw_before_reset");
    rst_n = 1'b0;
    bus_op(1'b0, 16'h8002, 16'h0, 1'b1, "reset_async_sw");
    bus_op(1'b1, 16'h0010, 16'hDEAD, 1'b1, "reset_async_wr_ram");
    bus_op(1'b1, 16'h8000, 16'h1111, 1'b1, "reset_async_wr_led");
    rst_n = 1'b1;
    bus_op(1'b0, 16'h0010, 16'h0, 1'b1, "ram_no_write_in_reset");
    bus_op(1'b0, 16'h8004, 16'h0, 1'b1, "tcount_after_reset");
    bus_op(1'b0, 16'h8006, 16'h0, 1'b1, "tctrl_after_reset");
    bus_op(1'b1, 16'h800A, 16'hFFFF, 1'b0, "wr");
    bus_op(1'b0, 16'h800A, 16'h0, 1'b1, "unmapped_after_reset");
    bus_op(1'b0, 16'h8000, 16'h0, 1'b1, "led_after_unmapped_wr");

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
